// File: rtl/ccx4_pkg.sv
// Shared types and sizing for the CCX4 nibble-serial coprocessor responder.
package ccx4_pkg;

  // Number of nibbles per 32-bit word and the width of a counter that indexes them
  localparam int NIBBLES = 8;
  localparam int CNT_W   = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RECV = 2'b01,
    EXEC = 2'b10,
    SEND = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_XOR  = 2'b01,
    OP_MINU = 2'b10,
    OP_MUL  = 2'b11
  } op_e;

endpackage

// File: rtl/ccx4_mul_nib.sv
// Iterative 32x4 multiplier: adds one shifted partial product (a * b nibble)
// per step. o_acc already includes the current step's partial product, so the
// caller can use it in the same cycle that o_done is high.
module ccx4_mul_nib
  import ccx4_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NIBW = 4
) (
  input  logic             clk_i,
  input  logic             rst_in,
  input  logic             i_start,
  input  logic             i_step,
  input  logic [XLEN-1:0]  i_a,
  input  logic [NIBW-1:0]  i_b_nib,
  input  logic [CNT_W-1:0] i_shift,
  output logic [XLEN-1:0]  o_acc,
  output logic             o_done
);

  logic [XLEN-1:0] r_acc;
  logic [XLEN-1:0] w_pp;
  logic [XLEN-1:0] w_pp_sh;

  // Bits of a*b_nib above XLEN would be shifted further out, so truncating early is safe
  assign w_pp    = i_a * XLEN'(i_b_nib);
  assign w_pp_sh = w_pp << (i_shift * NIBW);
  assign o_acc   = r_acc + w_pp_sh;
  assign o_done  = i_step && (i_shift == CNT_W'(NIBBLES - 1));

  // Accumulator: cleared by start, folds in one partial product per step
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      r_acc <= '0;
    end else if (i_start) begin
      r_acc <= '0;
    end else if (i_step) begin
      r_acc <= o_acc;
    end
  end

endmodule

// File: rtl/ccx4_responder.sv
// CCX4 responder: receives two operands LSN first over 8 cycles, executes the
// selected operation and streams the 32-bit result back LSN first.
module ccx4_responder
  import ccx4_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NIBW   = 4,
  parameter int MUL_EN = 1
) (
  input  logic            clk_i,
  input  logic            rst_in,
  input  logic [1:0]      ccx_sel_i,
  input  logic            ccx_req_i,
  input  logic [NIBW-1:0] ccx_rs_a_i,
  input  logic [NIBW-1:0] ccx_rs_b_i,
  output logic [NIBW-1:0] ccx_res_o,
  output logic            ccx_resp_o,
  output logic            busy_o,
  output logic            err_o
);

  state_e           r_state;
  op_e              r_op;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_a;
  logic [XLEN-1:0]  r_b;
  logic [XLEN-1:0]  r_shift;
  logic [NIBW-1:0]  r_res;
  logic             r_resp;
  logic             r_busy;
  logic             r_err;

  logic [XLEN-1:0]  w_alu;
  logic [XLEN-1:0]  w_mul_acc;
  logic             w_mul_done;
  logic             w_exec_done;
  logic             w_last_nib;

  assign ccx_res_o  = r_res;
  assign ccx_resp_o = r_resp;
  assign busy_o     = r_busy;
  assign err_o      = r_err;

  assign w_last_nib  = (r_cnt == CNT_W'(NIBBLES - 1));
  assign w_exec_done = (r_op != OP_MUL) || w_mul_done;

  // Multiplier only exists when enabled; otherwise MULLO yields 0 after one cycle
  generate
    if (MUL_EN != 0) begin : g_mul
      ccx4_mul_nib #(.XLEN(XLEN), .NIBW(NIBW)) u_mul (
        .clk_i   (clk_i),
        .rst_in  (rst_in),
        .i_start (r_state == IDLE),
        .i_step  ((r_state == EXEC) && (r_op == OP_MUL)),
        .i_a     (r_a),
        .i_b_nib (r_b[r_cnt*NIBW +: NIBW]),
        .i_shift (r_cnt),
        .o_acc   (w_mul_acc),
        .o_done  (w_mul_done)
      );
    end else begin : g_nomul
      assign w_mul_acc  = '0;
      assign w_mul_done = 1'b1;
    end
  endgenerate

  // Result selection for the latched operation
  always_comb begin
    w_alu = '0;
    case (r_op)
      OP_ADD:  w_alu = r_a + r_b;
      OP_XOR:  w_alu = r_a ^ r_b;
      OP_MINU: w_alu = (r_a < r_b) ? r_a : r_b;
      default: w_alu = w_mul_acc;
    endcase
  end

  // Protocol FSM; operands shift in from the top so nibble 0 lands at the bottom
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= IDLE;
      r_op    <= OP_ADD;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_shift <= '0;
      r_res   <= '0;
      r_resp  <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (ccx_req_i) begin
            r_a     <= {ccx_rs_a_i, r_a[XLEN-1:NIBW]};
            r_b     <= {ccx_rs_b_i, r_b[XLEN-1:NIBW]};
            r_op    <= op_e'(ccx_sel_i);
            r_cnt   <= CNT_W'(1);
            r_state <= RECV;
            r_busy  <= 1'b1;
          end
        end
        RECV: begin
          if (ccx_req_i) begin
            r_a <= {ccx_rs_a_i, r_a[XLEN-1:NIBW]};
            r_b <= {ccx_rs_b_i, r_b[XLEN-1:NIBW]};
            if (w_last_nib) begin
              r_cnt   <= '0;
              r_state <= EXEC;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else begin
            r_err   <= 1'b1;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        EXEC: begin
          if (ccx_req_i) r_err <= 1'b1;
          if (w_exec_done) begin
            r_cnt   <= '0;
            r_resp  <= 1'b1;
            r_res   <= w_alu[NIBW-1:0];
            r_shift <= w_alu >> NIBW;
            r_state <= SEND;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        SEND: begin
          if (ccx_req_i) r_err <= 1'b1;
          if (w_last_nib) begin
            r_cnt   <= '0;
            r_resp  <= 1'b0;
            r_res   <= '0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_res   <= r_shift[NIBW-1:0];
            r_shift <= r_shift >> NIBW;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccx4_responder.sv
// Directed bench for ccx4_responder: one instance with the multiplier, one without.
module tb_ccx4_responder;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic [1:0] sel = 2'b00;
  logic       req = 1'b0;
  logic [3:0] rsA = 4'h0;
  logic [3:0] rsB = 4'h0;

  logic [3:0] res1, res0;
  logic       resp1, resp0, busy1, busy0, err1, err0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ccx4_responder #(.XLEN(32), .NIBW(4), .MUL_EN(1)) dutMul (
    .clk_i(clk), .rst_in(rstN), .ccx_sel_i(sel), .ccx_req_i(req),
    .ccx_rs_a_i(rsA), .ccx_rs_b_i(rsB), .ccx_res_o(res1),
    .ccx_resp_o(resp1), .busy_o(busy1), .err_o(err1)
  );

  ccx4_responder #(.XLEN(32), .NIBW(4), .MUL_EN(0)) dutNoMul (
    .clk_i(clk), .rst_in(rstN), .ccx_sel_i(sel), .ccx_req_i(req),
    .ccx_rs_a_i(rsA), .ccx_rs_b_i(rsB), .ccx_res_o(res0),
    .ccx_resp_o(resp0), .busy_o(busy0), .err_o(err0)
  );

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic respOf(input int which);
    return (which != 0) ? resp1 : resp0;
  endfunction

  function automatic logic [3:0] resOf(input int which);
    return (which != 0) ? res1 : res0;
  endfunction

  function automatic logic errOf(input int which);
    return (which != 0) ? err1 : err0;
  endfunction

  // Drive n operand nibbles starting now (cycle T); sel is perturbed after nibble 0
  task automatic applyStimulus(input logic [1:0] s, input logic [31:0] a, input logic [31:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      req = 1'b1;
      sel = (i == 0) ? s : (s ^ 2'b01);
      rsA = a[4*i +: 4];
      rsB = b[4*i +: 4];
      tick();
    end
    req = 1'b0;
    sel = 2'b00;
    rsA = 4'h0;
    rsB = 4'h0;
  endtask

  // Called at T+8; returns assembled result and the cycle offset of the first resp
  task automatic getResult(input int which, input int pulseAt, output logic [31:0] result,
                           output int lat, output int respCycles, output int errCnt);
    result = 32'h0;
    lat = 8;
    respCycles = 0;
    errCnt = 0;
    while (!respOf(which) && lat < 40) begin
      errCnt += int'(errOf(which));
      tick();
      lat++;
    end
    for (int j = 0; j < 8; j++) begin
      respCycles += int'(respOf(which));
      result[4*j +: 4] = resOf(which);
      errCnt += int'(errOf(which));
      req = (j == pulseAt);
      tick();
    end
    req = 1'b0;
  endtask

  initial begin
    logic [31:0] result;
    int lat, respCycles, errCnt;
    bit sawResp;

    // Reset state
    tick();
    tick();
    checkOutput("rst_resp", 32'(resp1), 32'h0);
    checkOutput("rst_res", 32'(res1), 32'h0);
    checkOutput("rst_busy", 32'(busy1), 32'h0);
    checkOutput("rst_err", 32'(err1), 32'h0);
    rstN = 1'b1;
    tick();
    tick();

    // ADD 0xF + 1
    applyStimulus(2'b00, 32'h0000_000F, 32'h0000_0001, 8);
    checkOutput("add_busy_exec", 32'(busy1), 32'h1);
    checkOutput("add_resp_exec", 32'(resp1), 32'h0);
    getResult(1, -1, result, lat, respCycles, errCnt);
    checkOutput("add_result", result, 32'h0000_0010);
    checkOutput("add_latency", 32'(lat), 32'd9);
    checkOutput("add_resp_len", 32'(respCycles), 32'd8);
    checkOutput("add_err", 32'(errCnt), 32'd0);
    checkOutput("add_resp_after", 32'(resp1), 32'h0);
    checkOutput("add_busy_after", 32'(busy1), 32'h0);
    checkOutput("add_res_after", 32'(res1), 32'h0);
    tick();

    // MINU on large values
    applyStimulus(2'b10, 32'hFFFF_FFFE, 32'h8000_0000, 8);
    getResult(1, -1, result, lat, respCycles, errCnt);
    checkOutput("minu_result", result, 32'h8000_0000);
    checkOutput("minu_latency", 32'(lat), 32'd9);
    tick();

    // XOR of equal operands
    applyStimulus(2'b01, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 8);
    getResult(1, -1, result, lat, respCycles, errCnt);
    checkOutput("xor_result", result, 32'h0);
    checkOutput("xor_latency", 32'(lat), 32'd9);
    tick();

    // MULLO without multiplier: zero at ALU latency
    applyStimulus(2'b11, 32'h0001_0003, 32'h0001_0005, 8);
    getResult(0, -1, result, lat, respCycles, errCnt);
    checkOutput("nomul_result", result, 32'h0);
    checkOutput("nomul_latency", 32'(lat), 32'd9);
    repeat (10) tick();

    // MULLO with multiplier
    applyStimulus(2'b11, 32'h0001_0003, 32'h0001_0005, 8);
    getResult(1, -1, result, lat, respCycles, errCnt);
    checkOutput("mul_result", result, 32'h0008_000F);
    checkOutput("mul_latency", 32'(lat), 32'd16);
    checkOutput("mul_resp_len", 32'(respCycles), 32'd8);
    checkOutput("mul_busy_after", 32'(busy1), 32'h0);
    tick();

    // Abort after 3 nibbles
    applyStimulus(2'b00, 32'h0000_0007, 32'h0000_0007, 3);
    checkOutput("abort_err_t3", 32'(err1), 32'h0);
    tick();
    checkOutput("abort_err_t4", 32'(err1), 32'h1);
    tick();
    checkOutput("abort_err_t5", 32'(err1), 32'h0);
    checkOutput("abort_busy", 32'(busy1), 32'h0);
    sawResp = 1'b0;
    for (int k = 0; k < 12; k++) begin
      sawResp |= resp1;
      tick();
    end
    checkOutput("abort_no_resp", 32'(sawResp), 32'h0);

    applyStimulus(2'b00, 32'h0000_0001, 32'h0000_0002, 8);
    getResult(1, -1, result, lat, respCycles, errCnt);
    checkOutput("post_abort_add", result, 32'h0000_0003);
    tick();

    // req pulse during SEND, then back-to-back request
    applyStimulus(2'b00, 32'h1234_5678, 32'h1111_1111, 8);
    getResult(1, 3, result, lat, respCycles, errCnt);
    checkOutput("viol_result", result, 32'h2345_6789);
    checkOutput("viol_err_count", 32'(errCnt), 32'd1);
    checkOutput("viol_resp_len", 32'(respCycles), 32'd8);
    checkOutput("b2b_idle_resp", 32'(resp1), 32'h0);
    applyStimulus(2'b01, 32'hF0F0_1234, 32'h0FF0_4321, 8);
    getResult(1, -1, result, lat, respCycles, errCnt);
    checkOutput("b2b_result", result, 32'hFF00_5115);
    checkOutput("b2b_latency", 32'(lat), 32'd9);
    checkOutput("b2b_err", 32'(errCnt), 32'd0);
    tick();

    // Async reset during SEND nibble 4
    applyStimulus(2'b00, 32'h1111_1111, 32'h2222_2222, 8);
    repeat (5) tick();
    checkOutput("rst_mid_resp_before", 32'(resp1), 32'h1);
    checkOutput("rst_mid_res_before", 32'(res1), 32'h3);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("rst_mid_resp", 32'(resp1), 32'h0);
    checkOutput("rst_mid_res", 32'(res1), 32'h0);
    checkOutput("rst_mid_busy", 32'(busy1), 32'h0);
    tick();
    rstN = 1'b1;
    tick();
    applyStimulus(2'b00, 32'h0000_0005, 32'h0000_0006, 8);
    getResult(1, -1, result, lat, respCycles, errCnt);
    checkOutput("post_rst_add", result, 32'h0000_000B);
    checkOutput("post_rst_latency", 32'(lat), 32'd9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
